// File: rtl/memex_lsu.sv
// Memory/execute-result stage: ALU pass-through plus single-outstanding load/store
// over a req/ack bus, with lane steering, load extension and misalignment faults.
module memex_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_EX,
   input  logic        mem_read_EX,
   input  logic        mem_write_EX,
   input  logic [2:0]  funct3_EX,
   input  logic [3:0]  rd_EX,
   input  logic [31:0] alu_result_EX,
   input  logic [31:0] store_data_EX,
   input  logic        regfile_we_EX,
   output logic [3:0]  rd_MEMEX,
   output logic [31:0] alu_result_MEMEX,
   output logic        regfile_we_MEMEX,
   output logic        invalid_MEMEX,
   output logic        stall,
   output logic        mem_fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

   state_e      state_q, state_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] load_q, load_d;

   logic        is_mem, misaligned, f3_ok, fault;
   logic [1:0]  addr_lo;
   logic [3:0]  be_steer;
   logic [31:0] wdata_steer;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_ext;

   assign addr_lo = alu_result_EX[1:0];
   assign is_mem  = valid_EX & (mem_read_EX | mem_write_EX);

   always_comb begin
      misaligned = ((funct3_EX[1:0] == 2'b01) & addr_lo[0]) |
                   ((funct3_EX[1:0] == 2'b10) & (addr_lo != 2'b00));
      if (mem_read_EX) f3_ok = funct3_EX inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      else             f3_ok = funct3_EX inside {3'b000, 3'b001, 3'b010};
      fault = is_mem & ((mem_read_EX & mem_write_EX) | !f3_ok | misaligned);
   end

   // Lane steering is shared by loads and stores; only the width bits matter.
   always_comb begin
      case (funct3_EX[1:0])
         2'b00: begin
            be_steer    = 4'b0001 << addr_lo;
            wdata_steer = {4{store_data_EX[7:0]}};
         end
         2'b01: begin
            be_steer    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_steer = {2{store_data_EX[15:0]}};
         end
         default: begin
            be_steer    = 4'b1111;
            wdata_steer = store_data_EX;
         end
      endcase
   end

   always_comb begin
      case (addr_lo)
         2'b00:   rd_byte = mem_rdata[7:0];
         2'b01:   rd_byte = mem_rdata[15:8];
         2'b10:   rd_byte = mem_rdata[23:16];
         default: rd_byte = mem_rdata[31:24];
      endcase
      rd_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3_EX)
         3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
         3'b100:  load_ext = {24'h0, rd_byte};
         3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
         3'b101:  load_ext = {16'h0, rd_half};
         default: load_ext = mem_rdata;
      endcase
   end

   assign rd_MEMEX = rd_EX;

   always_comb begin
      state_d          = state_q;
      mem_req_d        = mem_req_q;
      mem_we_d         = mem_we_q;
      mem_addr_d       = mem_addr_q;
      mem_be_d         = mem_be_q;
      mem_wdata_d      = mem_wdata_q;
      load_d           = load_q;
      alu_result_MEMEX = alu_result_EX;
      regfile_we_MEMEX = regfile_we_EX & valid_EX & !mem_write_EX;
      invalid_MEMEX    = !valid_EX;
      stall            = 1'b0;
      mem_fault        = 1'b0;
      // In reset the stage is a pure pass-through regardless of the held state.
      if (!rst) begin
         case (state_q)
            StIdle: begin
               if (fault) begin
                  mem_fault        = 1'b1;
                  invalid_MEMEX    = 1'b1;
                  regfile_we_MEMEX = 1'b0;
               end else if (is_mem) begin
                  stall       = 1'b1;
                  state_d     = StReq;
                  mem_req_d   = 1'b1;
                  mem_we_d    = mem_write_EX;
                  mem_addr_d  = {alu_result_EX[31:2], 2'b00};
                  mem_be_d    = be_steer;
                  mem_wdata_d = mem_write_EX ? wdata_steer : 32'h0;
               end
            end
            StReq: begin
               stall = 1'b1;
               if (mem_ack) begin
                  load_d    = load_ext;
                  mem_req_d = 1'b0;
                  state_d   = StDone;
               end
            end
            StDone: begin
               if (mem_read_EX) alu_result_MEMEX = load_q;
               regfile_we_MEMEX = mem_read_EX ? regfile_we_EX : 1'b0;
               invalid_MEMEX    = 1'b0;
               state_d          = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_be_q    <= 4'h0;
         mem_wdata_q <= 32'h0;
         load_q      <= 32'h0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         load_q      <= load_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_memex_lsu.sv
// Self-checking bench for memex_lsu: scoreboard of expected stage results,
// with a simple req/ack bus responder driven from the op task.
module tb_memex_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_EX, mem_read_EX, mem_write_EX, regfile_we_EX;
   logic [2:0]  funct3_EX;
   logic [3:0]  rd_EX;
   logic [31:0] alu_result_EX, store_data_EX;
   logic [3:0]  rd_MEMEX;
   logic [31:0] alu_result_MEMEX;
   logic        regfile_we_MEMEX, invalid_MEMEX, stall, mem_fault;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] res;
      logic        we;
      logic        inv;
      logic        fault;
      int          stalls;
      int          req_cycles;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        bus_we;
   } exp_t;

   exp_t exp_q[$];

   memex_lsu dut (
      .clk              (clk),
      .rst              (rst),
      .valid_EX         (valid_EX),
      .mem_read_EX      (mem_read_EX),
      .mem_write_EX     (mem_write_EX),
      .funct3_EX        (funct3_EX),
      .rd_EX            (rd_EX),
      .alu_result_EX    (alu_result_EX),
      .store_data_EX    (store_data_EX),
      .regfile_we_EX    (regfile_we_EX),
      .rd_MEMEX         (rd_MEMEX),
      .alu_result_MEMEX (alu_result_MEMEX),
      .regfile_we_MEMEX (regfile_we_MEMEX),
      .invalid_MEMEX    (invalid_MEMEX),
      .stall            (stall),
      .mem_fault        (mem_fault),
      .mem_req          (mem_req),
      .mem_we           (mem_we),
      .mem_addr         (mem_addr),
      .mem_be           (mem_be),
      .mem_wdata        (mem_wdata),
      .mem_ack          (mem_ack),
      .mem_rdata        (mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Drives one instruction, answers the bus after ack_dly wait cycles, and
   // compares the presented result against the scoreboard head.
   task automatic run_op(input string tag, input logic v, r, w, input logic [2:0] f3,
                         input logic [31:0] addr, sd, rdata, input logic we,
                         input int ack_dly, input exp_t e);
      int   stalls = 0;
      int   waits  = 0;
      int   reqc   = 0;
      bit   done   = 0;
      logic [31:0] c_addr = 32'h0, c_wdata = 32'h0;
      logic [3:0]  c_be   = 4'h0;
      logic        c_we   = 1'b0;
      exp_t        x;
      valid_EX = v; mem_read_EX = r; mem_write_EX = w; funct3_EX = f3;
      alu_result_EX = addr; store_data_EX = sd; regfile_we_EX = we;
      rd_EX = addr[3:0];
      exp_q.push_back(e);
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (mem_req) begin
            if (reqc == 0) begin
               c_addr = mem_addr; c_be = mem_be; c_wdata = mem_wdata; c_we = mem_we;
            end
            reqc++;
            if (waits == ack_dly) begin
               mem_ack = 1'b1; mem_rdata = rdata;
            end else begin
               waits++;
            end
         end
         if (v && w) check({tag, "_st_we"}, 32'(regfile_we_MEMEX), 32'h0);
         if (!stall) begin
            done = 1;
            x = exp_q.pop_front();
            check({tag, "_res"},   alu_result_MEMEX, x.res);
            check({tag, "_we"},    32'(regfile_we_MEMEX), 32'(x.we));
            check({tag, "_inv"},   32'(invalid_MEMEX), 32'(x.inv));
            check({tag, "_fault"}, 32'(mem_fault), 32'(x.fault));
            check({tag, "_rd"},    32'(rd_MEMEX), 32'(addr[3:0]));
            check({tag, "_stall"}, stalls, x.stalls);
            check({tag, "_reqc"},  reqc, x.req_cycles);
            check({tag, "_reqlo"}, 32'(mem_req), 32'h0);
            if (x.req_cycles > 0) begin
               check({tag, "_addr"}, c_addr, x.addr);
               check({tag, "_be"},   32'(c_be), 32'(x.be));
               check({tag, "_bwe"},  32'(c_we), 32'(x.bus_we));
               if (x.bus_we) check({tag, "_wdata"}, c_wdata, x.wdata);
            end
         end else begin
            stalls++;
         end
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         mem_rdata = 32'hDEAD_BEEF;
      end
      if (!done) check({tag, "_timeout"}, 32'h0, 32'h1);
   endtask

   function automatic exp_t mk(input logic [31:0] res, input logic we, inv, fault,
                               input int stalls, reqc, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wdata,
                               input logic bus_we);
      exp_t e;
      e.res = res; e.we = we; e.inv = inv; e.fault = fault; e.stalls = stalls;
      e.req_cycles = reqc; e.addr = addr; e.be = be; e.wdata = wdata; e.bus_we = bus_we;
      return e;
   endfunction

   int c0;

   initial begin
      rst = 1'b1; valid_EX = 1'b0; mem_read_EX = 1'b0; mem_write_EX = 1'b0;
      funct3_EX = 3'b000; rd_EX = 4'd7; alu_result_EX = 32'hCAFE; store_data_EX = 32'h0;
      regfile_we_EX = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
      @(negedge clk);
      check("rst_stall", 32'(stall), 32'h0);
      check("rst_fault", 32'(mem_fault), 32'h0);
      check("rst_rd", 32'(rd_MEMEX), 32'd7);
      check("rst_alu", alu_result_MEMEX, 32'hCAFE);
      check("rst_req", 32'(mem_req), 32'h0);
      check("rst_bwe", 32'(mem_we), 32'h0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_be", 32'(mem_be), 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_op("alu", 1, 0, 0, 3'b000, 32'h1234, 0, 0, 1, 0,
             mk(32'h1234, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      run_op("lb", 1, 1, 0, 3'b000, 32'h103, 0, 32'h80AABBCC, 1, 0,
             mk(32'hFFFFFF80, 1, 0, 0, 2, 1, 32'h100, 4'b1000, 0, 0));
      run_op("lbu", 1, 1, 0, 3'b100, 32'h103, 0, 32'h80AABBCC, 1, 0,
             mk(32'h00000080, 1, 0, 0, 2, 1, 32'h100, 4'b1000, 0, 0));
      run_op("sh", 1, 0, 1, 3'b001, 32'h202, 32'h0000BEEF, 0, 1, 3,
             mk(32'h202, 0, 0, 0, 5, 4, 32'h200, 4'b1100, 32'hBEEFBEEF, 1));
      run_op("lw_mis", 1, 1, 0, 3'b010, 32'h101, 0, 0, 1, 0,
             mk(32'h101, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      run_op("ld_f3", 1, 1, 0, 3'b011, 32'h100, 0, 0, 1, 0,
             mk(32'h100, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      run_op("lh", 1, 1, 0, 3'b001, 32'h102, 0, 32'h80011234, 1, 1,
             mk(32'hFFFF8001, 1, 0, 0, 3, 2, 32'h100, 4'b1100, 0, 0));
      run_op("lhu", 1, 1, 0, 3'b101, 32'h100, 0, 32'h80019234, 1, 0,
             mk(32'h00009234, 1, 0, 0, 2, 1, 32'h100, 4'b0011, 0, 0));
      run_op("sb", 1, 0, 1, 3'b000, 32'h301, 32'h123456A5, 0, 1, 0,
             mk(32'h301, 0, 0, 0, 2, 1, 32'h300, 4'b0010, 32'hA5A5A5A5, 1));
      run_op("sw", 1, 0, 1, 3'b010, 32'h308, 32'h89ABCDEF, 0, 1, 1,
             mk(32'h308, 0, 0, 0, 3, 2, 32'h308, 4'b1111, 32'h89ABCDEF, 1));
      run_op("sh_mis", 1, 0, 1, 3'b001, 32'h303, 32'h1, 0, 1, 0,
             mk(32'h303, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      run_op("st_f3", 1, 0, 1, 3'b100, 32'h300, 32'h1, 0, 1, 0,
             mk(32'h300, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      run_op("rdwr", 1, 1, 1, 3'b010, 32'h300, 32'h1, 0, 1, 0,
             mk(32'h300, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      run_op("bubble", 0, 1, 0, 3'b010, 32'h400, 0, 0, 1, 0,
             mk(32'h400, 0, 1, 0, 0, 0, 0, 0, 0, 0));

      c0 = cyc;
      run_op("lw0", 1, 1, 0, 3'b010, 32'h10, 0, 32'h11111111, 1, 0,
             mk(32'h11111111, 1, 0, 0, 2, 1, 32'h10, 4'b1111, 0, 0));
      run_op("lw1", 1, 1, 0, 3'b010, 32'h14, 0, 32'h22222222, 1, 0,
             mk(32'h22222222, 1, 0, 0, 2, 1, 32'h14, 4'b1111, 0, 0));
      check("b2b_cycles", cyc - c0, 6);

      // Reset while a load waits in REQ; the late ack must be ignored.
      valid_EX = 1'b1; mem_read_EX = 1'b1; mem_write_EX = 1'b0; funct3_EX = 3'b010;
      alu_result_EX = 32'h40; regfile_we_EX = 1'b1;
      @(negedge clk);
      check("rr_stall0", 32'(stall), 32'h1);
      @(posedge clk); #1;
      @(negedge clk);
      check("rr_req", 32'(mem_req), 32'h1);
      rst = 1'b1;
      #1;
      check("rr_stall_rst", 32'(stall), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; valid_EX = 1'b0; mem_read_EX = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      @(negedge clk);
      check("rr_req_lo", 32'(mem_req), 32'h0);
      check("rr_state", 32'(dut.state_q), 32'h0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(negedge clk);
      check("rr_load_q", dut.load_q, 32'h0);
      check("rr_state2", 32'(dut.state_q), 32'h0);
      check("rr_req2", 32'(mem_req), 32'h0);
      check("rr_stall2", 32'(stall), 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
